// File: rtl/dac_code_coverage_pkg.sv
// dac_code_coverage_pkg
//   Shared definitions for the DAC code-coverage monitor: default bus and
//   code-range sizes, the FSM state encoding and a helper that classifies
//   states as busy.
package dac_code_coverage_pkg;

  localparam int DEF_CODE_W     = 12;
  localparam int DEF_CODE_LIMIT = 2048;
  localparam int DEF_WINDOW_W   = 20;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SCAN  = 3'd4,
    ST_DONE  = 3'd5
  } cov_state_t;

  function automatic logic state_is_busy(input cov_state_t s);
    return (s == ST_CLEAR) || (s == ST_RUN) || (s == ST_DRAIN) || (s == ST_SCAN);
  endfunction

endpackage

// File: rtl/dac_code_coverage_bitmap.sv
// cov_bitmap_ram
//   1-bit x 2^ADDR_W hit bitmap. One write port, one synchronous read port
//   (read-before-write on an address collision), no reset, so it maps onto
//   a block RAM.
//   Ports: clk; we/waddr/wdata write port; raddr -> rdata one cycle later.
module cov_bitmap_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic              rdata
);

  logic mem [2**ADDR_W];
  logic rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dac_code_coverage.sv
// dac_code_coverage
//   Records which DAC codes 0..CODE_LIMIT-1 appear during a programmed
//   window, counts unique codes, finds the lowest missing code and exposes
//   the hit bitmap through a read port once the measurement is done.
//   Ports:
//     clk, reset (async, active low)
//     start, window_len        : begin a measurement of window_len RUN cycles
//     code_valid, code_in      : monitored DAC bus
//     busy, done               : measurement status
//     hits, all_hit, missing_first, out_of_range : results
//     rd_addr -> rd_data       : bitmap readout in DONE, 1-cycle latency
//     dbg_state                : current FSM state
//   Handshake: start is a single-cycle request honoured only in IDLE/DONE;
//   code_valid qualifies code_in every cycle with no ready -- the monitor
//   accepts a sample on every RUN cycle and never back-pressures.
module dac_code_coverage
  import dac_code_coverage_pkg::*;
#(
  parameter int CODE_W     = DEF_CODE_W,
  parameter int CODE_LIMIT = DEF_CODE_LIMIT,
  parameter int WINDOW_W   = DEF_WINDOW_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WINDOW_W-1:0] window_len,
  input  logic                code_valid,
  input  logic [CODE_W-1:0]   code_in,
  output logic                busy,
  output logic                done,
  output logic [CODE_W:0]     hits,
  output logic                all_hit,
  output logic [CODE_W:0]     missing_first,
  output logic                out_of_range,
  input  logic [CODE_W-1:0]   rd_addr,
  output logic                rd_data,
  output logic [2:0]          dbg_state
);

  localparam logic [CODE_W:0] LIMIT = (CODE_W+1)'(CODE_LIMIT);
  localparam logic [CODE_W:0] LAST  = LIMIT - 1'b1;

  cov_state_t          state_q, state_d;
  logic [WINDOW_W-1:0] win_q, win_d;
  logic [CODE_W:0]     cnt_q, cnt_d;      // clear address, then scan address
  logic                s1_valid_q, s1_valid_d;
  logic                s1_fwd_q, s1_fwd_d;
  logic [CODE_W-1:0]   s1_addr_q, s1_addr_d;
  logic [CODE_W:0]     hits_q, hits_d;
  logic [CODE_W:0]     missing_q, missing_d;
  logic                oor_q, oor_d;

  logic              ram_we;
  logic [CODE_W-1:0] ram_waddr;
  logic              ram_wdata;
  logic [CODE_W-1:0] ram_raddr;
  logic              ram_rdata;
  logic              bit_seen;

  cov_bitmap_ram #(.ADDR_W(CODE_W)) u_bitmap (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // The RAM returns pre-write data on a collision, so a read of the address
  // being written this cycle carries a forward flag that forces the bit to 1.
  assign bit_seen = ram_rdata | s1_fwd_q;

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    s1_valid_d = 1'b0;
    s1_fwd_d   = 1'b0;
    s1_addr_d  = s1_addr_q;
    hits_d     = hits_q;
    missing_d  = missing_q;
    oor_d      = oor_q;
    ram_we     = 1'b0;
    ram_waddr  = s1_addr_q;
    ram_wdata  = 1'b1;
    ram_raddr  = rd_addr;

    // Stage 1: retire the sample read last cycle (RUN and DRAIN only).
    if (s1_valid_q && !bit_seen) begin
      ram_we = 1'b1;
      if (hits_q != LIMIT) begin
        hits_d = hits_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_CLEAR;
          win_d     = (window_len == '0) ? WINDOW_W'(1) : window_len;
          cnt_d     = '0;
          hits_d    = '0;
          missing_d = '0;
          oor_d     = 1'b0;
        end
      end
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q[CODE_W-1:0];
        ram_wdata = 1'b0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        win_d = win_q - 1'b1;
        if (win_q == WINDOW_W'(1)) begin
          state_d = ST_DRAIN;
        end
        if (code_valid) begin
          if ({1'b0, code_in} >= LIMIT) begin
            oor_d = 1'b1;
          end else begin
            ram_raddr  = code_in;
            s1_valid_d = 1'b1;
            s1_addr_d  = code_in;
            s1_fwd_d   = s1_valid_q && (s1_addr_q == code_in);
          end
        end
      end
      ST_DRAIN: begin
        // Prefetch address 0 so each SCAN cycle resolves one address.
        ram_raddr = '0;
        cnt_d     = '0;
        s1_fwd_d  = ram_we && (s1_addr_q == '0);
        if (hits_d == LIMIT) begin
          missing_d = LIMIT;
          state_d   = ST_DONE;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        ram_raddr = cnt_q[CODE_W-1:0] + 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (!bit_seen) begin
          missing_d = cnt_q;
          state_d   = ST_DONE;
        end else if (cnt_q == LAST) begin
          missing_d = LIMIT;
          state_d   = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      win_q      <= '0;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_fwd_q   <= 1'b0;
      s1_addr_q  <= '0;
      hits_q     <= '0;
      missing_q  <= '0;
      oor_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_fwd_q   <= s1_fwd_d;
      s1_addr_q  <= s1_addr_d;
      hits_q     <= hits_d;
      missing_q  <= missing_d;
      oor_q      <= oor_d;
    end
  end

  assign busy          = state_is_busy(state_q);
  assign done          = (state_q == ST_DONE);
  assign hits          = hits_q;
  assign all_hit       = (hits_q == LIMIT);
  assign missing_first = missing_q;
  assign out_of_range  = oor_q;
  // The RAM output is unreset; gate it so it reads 0 outside DONE.
  assign rd_data       = done & ram_rdata;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_dac_code_coverage.sv
// tb_dac_code_coverage
//   Drives measurement windows of several code patterns, keeps a reference
//   bitmap, and compares results, timing and bitmap readout to the DUT.
module tb_dac_code_coverage;
  import dac_code_coverage_pkg::*;

  localparam int CODE_W   = 12;
  localparam int LIMIT    = 2048;
  localparam int WINDOW_W = 20;

  logic                clk;
  logic                reset;
  logic                start;
  logic [WINDOW_W-1:0] window_len;
  logic                code_valid;
  logic [CODE_W-1:0]   code_in;
  logic                busy;
  logic                done;
  logic [CODE_W:0]     hits;
  logic                all_hit;
  logic [CODE_W:0]     missing_first;
  logic                out_of_range;
  logic [CODE_W-1:0]   rd_addr;
  logic                rd_data;
  logic [2:0]          dbg_state;

  dac_code_coverage #(
    .CODE_W(CODE_W), .CODE_LIMIT(LIMIT), .WINDOW_W(WINDOW_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .window_len(window_len),
    .code_valid(code_valid), .code_in(code_in), .busy(busy), .done(done),
    .hits(hits), .all_hit(all_hit), .missing_first(missing_first),
    .out_of_range(out_of_range), .rd_addr(rd_addr), .rd_data(rd_data),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  bit ref_map [LIMIT];
  int ref_hits;
  bit ref_oor;
  int alt_codes [6] = '{5, 5, 7, 5, 7, 7};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [31:0] got);
    logic [31:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check_eq(tag, got, e);
  endtask

  function automatic int ref_missing();
    for (int a = 0; a < LIMIT; a++) begin
      if (!ref_map[a]) return a;
    end
    return LIMIT;
  endfunction

  task automatic model_sample(input logic v, input logic [CODE_W-1:0] c);
    if (v) begin
      if (int'(c) >= LIMIT) begin
        ref_oor = 1'b1;
      end else if (!ref_map[c]) begin
        ref_map[c] = 1'b1;
        ref_hits++;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic gen(input int mode, input int i, output logic v, output logic [CODE_W-1:0] c);
    v = 1'b1;
    c = '0;
    case (mode)
      0: c = CODE_W'(i);                                   // ramp
      1: c = CODE_W'(100);                                 // constant
      2: c = (i < 1000) ? CODE_W'(i) : CODE_W'(i + 1);     // ramp skipping 1000
      3: begin                                             // hazard pattern
        if (i < 6) c = CODE_W'(alt_codes[i]);
        else v = 1'b0;
      end
      4: begin                                             // ramp with 3000 injected
        if (i < 1000)       c = CODE_W'(i);
        else if (i == 1000) c = CODE_W'(3000);
        else                c = CODE_W'(i - 1);
      end
      5: c = CODE_W'(i);                                   // short ramp
      6: c = CODE_W'(42);
      default: begin                                       // random
        v = ($urandom_range(0, 3) != 0);
        c = CODE_W'($urandom_range(0, 2100));
      end
    endcase
  endtask

  task automatic do_reset_checks();
    reset = 1'b0;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_hits", hits, 0);
    check_eq("rst_missing", missing_first, 0);
    check_eq("rst_oor", out_of_range, 0);
    check_eq("rst_all_hit", all_hit, 0);
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_state", dbg_state, ST_IDLE);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_window(input int mode, input int wlen, input int abort_at);
    int n;
    int j;
    int k;
    logic v;
    logic [CODE_W-1:0] c;
    n = (wlen == 0) ? 1 : wlen;
    for (int a = 0; a < LIMIT; a++) ref_map[a] = 1'b0;
    ref_hits = 0;
    ref_oor  = 1'b0;

    start      = 1'b1;
    window_len = WINDOW_W'(wlen);
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    check_eq("done_after_start", done, 0);

    j = 0;
    @(negedge clk);
    while (dbg_state != ST_RUN && j < 3 * LIMIT) begin
      @(negedge clk);
      j++;
    end
    check_eq("clear_cycles", j, LIMIT);

    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        code_valid = 1'b0;
        do_reset_checks();
        return;
      end
      gen(mode, i, v, c);
      code_valid = v;
      code_in    = c;
      model_sample(v, c);
      @(negedge clk);
    end
    code_valid = 1'b0;
    check_eq("window_end_drain", dbg_state, ST_DRAIN);

    k = ref_missing();
    exp_q.push_back((ref_hits == LIMIT) ? 1 : k + 2);
    exp_q.push_back(0);
    exp_q.push_back(ref_hits);
    exp_q.push_back(k);
    exp_q.push_back(ref_oor);
    exp_q.push_back(ref_hits == LIMIT);

    j = 0;
    while (!done && j < 3 * LIMIT) begin
      @(negedge clk);
      j++;
    end
    pop_check("done_latency", j);
    pop_check("busy_at_done", busy);
    pop_check("hits", hits);
    pop_check("missing_first", missing_first);
    pop_check("out_of_range", out_of_range);
    pop_check("all_hit", all_hit);
  endtask

  task automatic read_bit(input int addr);
    exp_q.push_back(ref_map[addr]);
    rd_addr = CODE_W'(addr);
    @(posedge clk);
    @(posedge clk);
    #1;
    pop_check("rd_data", rd_data);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    window_len = '0;
    code_valid = 1'b0;
    code_in    = '0;
    rd_addr    = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_hits", hits, 0);
    check_eq("reset_missing", missing_first, 0);
    check_eq("reset_state", dbg_state, ST_IDLE);
    reset = 1'b1;
    @(negedge clk);

    run_window(0, 2048, -1);   // full ramp
    read_bit(0);
    read_bit(2047);
    run_window(1, 500, -1);    // constant 100
    read_bit(100);
    read_bit(101);
    run_window(2, 2047, -1);   // ramp without 1000
    read_bit(1000);
    read_bit(999);
    run_window(3, 20, -1);     // 5,5,7,5,7,7 hazard
    read_bit(5);
    read_bit(6);
    run_window(4, 2049, -1);   // out-of-range code mid-ramp
    run_window(0, 2048, 300);  // reset mid-RUN
    run_window(5, 10, -1);     // 0..9 after abort
    read_bit(9);
    read_bit(10);
    run_window(6, 0, -1);      // zero window acts as one cycle
    run_window(7, 3000, -1);   // random codes
    read_bit($urandom_range(0, LIMIT - 1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
